// File: rtl/csa_acc_pkg.sv
// Shared types, default widths and saturation helper for the CSA resolve accumulator.
// CSA_ACC_SATURATE_EN selects clamping on overflow; otherwise results wrap.
package csa_acc_pkg;

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam int IN_WIDTH_DEF      = 16;
    localparam int ACC_WIDTH_DEF     = 32;
    localparam int CNT_WIDTH_DEF     = 8;
    localparam int CARRY_SHIFTED_DEF = 1;

    // Clamp pattern as {msb, fill}; the clamp value is {msb, {ACC_WIDTH-1{fill}}}.
    function automatic logic [1:0] sat_value(logic is_signed, logic neg);
        if (!is_signed) begin
            return 2'b11;
        end
        return neg ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/csa_acc_cpa_stage.sv
// Combinational carry-propagate resolve of a sum/carry pair, plus extension of a
// registered resolved beat to accumulator width.
module csa_cpa_stage
    import csa_acc_pkg::*;
#(
    parameter int IN_WIDTH      = IN_WIDTH_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int CARRY_SHIFTED = CARRY_SHIFTED_DEF
) (
    input  logic [IN_WIDTH-1:0]  sum_i,
    input  logic [IN_WIDTH-1:0]  carry_i,
    input  logic [IN_WIDTH-1:0]  res_i,
    input  logic                 is_signed_i,
    output logic [IN_WIDTH-1:0]  res_o,
    output logic [ACC_WIDTH-1:0] ext_o
);

    logic [IN_WIDTH-1:0] carry_w;

    // Unweighted carry vectors lose their MSB on the shift, matching the tree's modulo arithmetic.
    if (CARRY_SHIFTED != 0) begin : g_carry_weighted
        assign carry_w = carry_i;
    end else begin : g_carry_shift
        assign carry_w = {carry_i[IN_WIDTH-2:0], 1'b0};
    end

    assign res_o = sum_i + carry_w;

    if (ACC_WIDTH > IN_WIDTH) begin : g_extend
        assign ext_o = is_signed_i ? {{(ACC_WIDTH-IN_WIDTH){res_i[IN_WIDTH-1]}}, res_i}
                                   : {{(ACC_WIDTH-IN_WIDTH){1'b0}}, res_i};
    end else begin : g_no_extend
        logic unused_signed;
        assign unused_signed = is_signed_i;
        assign ext_o = res_i;
    end

endmodule

// File: rtl/csa_resolve_accumulator.sv
// Two-stage resolve (CPA) and accumulate of compressor-tree output over a group of beats.
// Build option CSA_ACC_SATURATE_EN clamps the accumulator on beat overflow.
//
// state | meaning
// S_ACC | stage 2 consumes stage-1 beats into the accumulator
// S_OUT | a group result is presented and waits for out_ready_i
module csa_resolve_accumulator
    import csa_acc_pkg::*;
#(
    parameter int IN_WIDTH      = IN_WIDTH_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int CARRY_SHIFTED = CARRY_SHIFTED_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IN_WIDTH-1:0]  sum_i,
    input  logic [IN_WIDTH-1:0]  carry_i,
    input  logic                 is_signed_i,
    input  logic                 in_last_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [ACC_WIDTH-1:0] result_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 overflow_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [IN_WIDTH-1:0]    res1_q, res1_d;
    logic                   v1_q, v1_d;
    logic                   s1_q, s1_d;
    logic                   l1_q, l1_d;
    logic [ACC_WIDTH-1:0]   result_q, result_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   out_valid_q, out_valid_d;

    logic [IN_WIDTH-1:0]    cpa_res;
    logic [ACC_WIDTH-1:0]   ext;
    logic [ACC_WIDTH:0]     nxt_full;
    logic [ACC_WIDTH-1:0]   nxt;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   beat_ovf;
    logic                   in_hs;
    logic                   consume;

    csa_cpa_stage #(
        .IN_WIDTH      (IN_WIDTH),
        .ACC_WIDTH     (ACC_WIDTH),
        .CARRY_SHIFTED (CARRY_SHIFTED)
    ) u_cpa (
        .sum_i       (sum_i),
        .carry_i     (carry_i),
        .res_i       (res1_q),
        .is_signed_i (s1_q),
        .res_o       (cpa_res),
        .ext_o       (ext)
    );

    assign in_ready_o = rst_ni && (!v1_q || (state_q == S_ACC));
    assign in_hs      = in_valid_i && in_ready_o;
    assign consume    = v1_q && (state_q == S_ACC);

    assign nxt_full = {1'b0, acc_q} + {1'b0, ext};
    assign nxt      = nxt_full[ACC_WIDTH-1:0];
    assign beat_ovf = s1_q ? ((acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                              (nxt[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                           : nxt_full[ACC_WIDTH];
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef CSA_ACC_SATURATE_EN
    logic [1:0] sat_pat;
    assign sat_pat = sat_value(s1_q, ext[ACC_WIDTH-1]);
    assign acc_sum = beat_ovf ? {sat_pat[1], {(ACC_WIDTH-1){sat_pat[0]}}} : nxt;
`else
    assign acc_sum = nxt;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res1_d      = res1_q;
        v1_d        = v1_q;
        s1_d        = s1_q;
        l1_d        = l1_q;
        result_d    = result_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;

        if (in_hs) begin
            res1_d = cpa_res;
            v1_d   = 1'b1;
            s1_d   = is_signed_i;
            l1_d   = in_last_i;
        end else if (consume) begin
            v1_d = 1'b0;
        end

        case (state_q)
            S_ACC: begin
                if (v1_q) begin
                    if (!l1_q) begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | beat_ovf;
                    end else begin
                        result_d    = acc_sum;
                        count_d     = cnt_inc;
                        overflow_d  = ovf_q | beat_ovf;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res1_q      <= '0;
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            l1_q        <= 1'b0;
            result_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res1_q      <= res1_d;
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            l1_q        <= l1_d;
            result_q    <= result_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result_o    = result_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: doc/csa_resolve_accumulator.md
Name: csa_resolve_accumulator

Overview:
- Consumer end of the compressor tree's redundant sum/carry output.
- Resolves each sum/carry pair with a carry-propagate add, then sign- or zero-extends the result and accumulates it over a multi-beat dot product.
- Emits one binary result per group, marked by `in_last_i`.
- Sits between the 8:2 compressor array and the AI core's writeback/requantisation path.

Parameters:
- `IN_WIDTH`, 16: width of incoming sum/carry vectors.
- `ACC_WIDTH`, 32: accumulator and result width; must be ≥ `IN_WIDTH`.
- `CARRY_SHIFTED`, 1: 1 means the carry vector is already weighted; 0 means the block shifts carry left by 1 (MSB dropped) before adding.
- `CNT_WIDTH`, 8: width of the beat counter.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: synchronous active-low reset.
- `sum_i`, input, `IN_WIDTH`: redundant sum vector.
- `carry_i`, input, `IN_WIDTH`: redundant carry vector.
- `is_signed_i`, input, 1: beat is two's complement (1) or unsigned (0).
- `in_last_i`, input, 1: final beat of the current group.
- `in_valid_i`, input, 1: input beat valid.
- `in_ready_o`, output, 1: block can accept a beat.
- `result_o`, output, `ACC_WIDTH`: accumulated group result.
- `count_o`, output, `CNT_WIDTH`: number of beats in the result.
- `overflow_o`, output, 1: sticky overflow seen during the group.
- `out_valid_o`, output, 1: result valid.
- `out_ready_i`, input, 1: downstream accepts result.

Behaviour:
- Reset is synchronous active-low on `clk_i`, which is the only clock. While `rst_ni` is 0 at an edge, the following clear to 0: accumulator, beat counter, overflow flag, stage-1 registers, `result_o`, `count_o`, `overflow_o`, `out_valid_o`. State returns to `S_ACC`.
- Reset mid-group or mid-output discards all partial state; no result is emitted.
- `in_ready_o` is 0 during reset.
- Stage 1 (CPA):
  - On an input handshake (`in_valid_i && in_ready_o`), register `res1 = (sum_i + carry_w) mod 2^IN_WIDTH`.
  - `carry_w` = `carry_i` if `CARRY_SHIFTED`, else `carry_i << 1`.
  - Also register `v1 = 1`, `s1 = is_signed_i`, `l1 = in_last_i`.
  - If there is no handshake and stage 2 consumes, `v1` clears.
- Stage 2 (accumulate):
  - Extend `res1` to `ACC_WIDTH`: sign-extend if `s1`, else zero-extend.
  - `nxt = acc + ext`. Overflow of a beat:
    - signed (`s1=1`): `acc` and `ext` MSBs are equal and `nxt` MSB differs;
    - unsigned: carry out of bit `ACC_WIDTH-1`.
  - `cnt` increments by 1 per consumed beat and saturates at all-ones.
- State machine:
  - `S_ACC`: stage 2 consumes `v1` every cycle.
    - If `l1=0`: `acc<=nxt`, `cnt<=cnt+1`, `ovf<=ovf|beat_ovf`.
    - If `l1=1`: `result_o<=nxt`, `count_o<=cnt+1`, `overflow_o<=ovf|beat_ovf`, `out_valid_o<=1`; clear `acc`, `cnt` and `ovf`; go to `S_OUT`.
  - `S_OUT`: stage 2 does not consume.
    - On `out_ready_i=1`: `out_valid_o<=0`, go to `S_ACC`.
- Handshake rules:
  - `in_ready_o = !v1 || (state==S_ACC)`.
  - In `S_OUT` with `v1=1`, input stalls; with `v1=0`, one beat may be buffered in stage 1.
  - Outputs are stable while `out_valid_o && !out_ready_i`.
- Latency:
  - Last beat accepted at cycle N → `out_valid_o` at N+2 (one cycle in stage 1, one in stage 2).
  - Sustained throughput is 1 beat/cycle except while a result waits.
- A single-beat group (`in_last_i=1` on the first beat) gives `result_o` = extended beat and `count_o=1`.
- `is_signed_i` is honoured per beat; mixing within a group is legal, and overflow is judged per beat's mode.

Optional Feature:
- Macro: `CSA_ACC_SATURATE_EN`.
- Defined: on beat overflow, the accumulator (and `result_o` for the last beat) clamps.
  - Signed: `2^(ACC_WIDTH-1)-1` if `ext` is non-negative, else `-2^(ACC_WIDTH-1)`.
  - Unsigned: all-ones.
  - `overflow_o` still reports.
- Not defined: results wrap modulo `2^ACC_WIDTH` and `overflow_o` reports only.

Decomposition:
- Package `csa_acc_pkg`:
  - `state_t` enum `{S_ACC, S_OUT}`;
  - default width localparams;
  - `function sat_value(logic is_signed, logic neg)`.
- Sub-module `csa_cpa_stage`: combinational resolve, carry weighting and extension, parameterised by `IN_WIDTH`, `ACC_WIDTH`, `CARRY_SHIFTED`. It is instantiated once; the top holds the registers and FSM.

Test Plan:
- Unsigned group:
  - Stimulus: `IN_WIDTH=16`, beats (`sum`,`carry`) = (0x0003, 0x0001), (0x0010, 0x0000), last (0x0100, 0x0001), `CARRY_SHIFTED=1`.
  - Required: `result_o=0x115`, `count_o=3`, `overflow_o=0`, `out_valid_o` 2 cycles after the last handshake.
- Signed group:
  - Stimulus: beats resolving to 0xFFFE (-2) and 0x0001, last, `is_signed=1`.
  - Required: `result_o=0xFFFFFFFF`, `count_o=2`.
- Back-pressure:
  - Stimulus: hold `out_ready_i=0` for 5 cycles with back-to-back groups.
  - Required: `result_o` stable; exactly one beat is buffered and then `in_ready_o=0`. After ready, the next group is accumulated correctly with no lost or duplicated beat.
- Overflow:
  - Stimulus: `ACC_WIDTH=IN_WIDTH=16`, signed beats 0x7FFF then 0x0001 (last).
  - Required: `overflow_o=1`. Result is 0x8000 without the macro, 0x7FFF with `CSA_ACC_SATURATE_EN`.
- Carry weighting:
  - Stimulus: `CARRY_SHIFTED=0`, `sum=0x0001`, `carry=0x0001`, last.
  - Required: `result_o=0x3`.
- Reset mid-group:
  - Stimulus: 2 beats accepted, `rst_ni=0` for 1 cycle, then a single beat 0x0005 last.
  - Required: `result_o=0x5`, `count_o=1`, and `out_valid_o` stays 0 until then.
